// File: rtl/mastermind_ctrl.sv
// Mastermind game controller: peg-by-peg code/guess entry from one load button,
// per-peg compare sweep, hit scoring, win/lose. Optional macro: MM_GUESS_LIMIT_EN.
module mastermind_ctrl #(
    parameter int NUM_PEGS    = 4,
    parameter int MAX_GUESSES = 10,
    parameter int IDX_W       = $clog2(NUM_PEGS),
    parameter int HIT_W       = $clog2(NUM_PEGS + 1),
    parameter int GW          = $clog2(MAX_GUESSES + 1)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                load,
    input  logic                exact_hit,
    output logic [NUM_PEGS-1:0] load_code,
    output logic [NUM_PEGS-1:0] load_guess,
    output logic                compare,
    output logic [IDX_W-1:0]    compare_i,
    output logic                score_valid,
    output logic [HIT_W-1:0]    hit_count,
    output logic [GW-1:0]       guess_num,
    output logic                win,
    output logic                lose
);

    localparam logic [3:0] S_CODE       = 4'd0;
    localparam logic [3:0] S_CODE_WAIT  = 4'd1;
    localparam logic [3:0] S_GUESS      = 4'd2;
    localparam logic [3:0] S_GUESS_WAIT = 4'd3;
    localparam logic [3:0] S_RESULT     = 4'd4;
    localparam logic [3:0] S_SCORE      = 4'd5;
    localparam logic [3:0] S_WIN        = 4'd6;
    localparam logic [3:0] S_LOSE       = 4'd7;
    localparam logic [3:0] S_RESTART    = 4'd8;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PEGS - 1);
    localparam logic [HIT_W-1:0] FULL_HITS = HIT_W'(NUM_PEGS);
    localparam logic [GW-1:0]    GN_SAT    = {GW{1'b1}};
    localparam logic [GW-1:0]    GN_LIMIT  = GW'(MAX_GUESSES);

    logic [3:0]       state;
    logic [IDX_W-1:0] idx;
    logic [HIT_W-1:0] acc;
    logic [HIT_W-1:0] acc_next;
    logic [GW-1:0]    gn_next;
    logic             win_q;
    logic             lose_q;

    assign acc_next = acc + HIT_W'(exact_hit);
    assign gn_next  = (guess_num == GN_SAT) ? guess_num : guess_num + 1'b1;

    // Score, guess count and win/lose are all committed on the last sweep edge,
    // so they change together with the rise of score_valid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_CODE;
            idx       <= '0;
            acc       <= '0;
            hit_count <= '0;
            guess_num <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order in this block.
            case (state)
                S_CODE: if (load) state <= S_CODE_WAIT;
                S_CODE_WAIT: begin
                    if (!load) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_GUESS;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_CODE;
                        end
                    end
                end
                S_GUESS: if (load) state <= S_GUESS_WAIT;
                S_GUESS_WAIT: begin
                    if (!load) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            acc   <= '0;
                            state <= S_RESULT;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_GUESS;
                        end
                    end
                end
                S_RESULT: begin
                    acc <= acc_next;
                    if (idx == LAST_IDX) begin
                        idx       <= '0;
                        hit_count <= acc_next;
                        guess_num <= gn_next;
                        win_q     <= (acc_next == FULL_HITS);
`ifdef MM_GUESS_LIMIT_EN
                        lose_q    <= (acc_next != FULL_HITS) && (gn_next == GN_LIMIT);
`else
                        lose_q    <= 1'b0;
`endif
                        state     <= S_SCORE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_SCORE: begin
                    if (win_q)       state <= S_WIN;
                    else if (lose_q) state <= S_LOSE;
                    else             state <= S_GUESS;
                end
                S_WIN, S_LOSE: begin
                    if (load) begin
                        win_q  <= 1'b0;
                        lose_q <= 1'b0;
                        state  <= S_RESTART;
                    end
                end
                S_RESTART: begin
                    if (!load) begin
                        idx       <= '0;
                        hit_count <= '0;
                        guess_num <= '0;
                        state     <= S_CODE;
                    end
                end
                default: state <= S_CODE;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the decode so no latch is inferred.
        load_code  = '0;
        load_guess = '0;
        if (state == S_CODE)  load_code[idx]  = 1'b1;
        if (state == S_GUESS) load_guess[idx] = 1'b1;
    end

    assign compare     = (state == S_RESULT);
    assign compare_i   = compare ? idx : '0;
    assign score_valid = (state == S_SCORE);
    assign win         = win_q;
`ifdef MM_GUESS_LIMIT_EN
    assign lose        = lose_q;
`else
    assign lose        = 1'b0;
`endif

endmodule
